sobol_fp16_scheduler: RTL and testbench
=======================================

SOBOL_FP16_SCHEDULER -- requirements
Module: sobol_fp16_scheduler

Interface
REQ-001 SHALL have parameter N_REQ, default 4: number of Sobol dimension requesters sharing one INT32-to-FP16 conversion stage (fixed at 4 for this release).
REQ-002 SHALL have parameter LEN_W, default 16: width of the run-length counter.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst_n  input  1: asynchronous, active-low reset.
REQ-005 SHALL have port start  input  1: one-cycle pulse; begins a run when in IDLE, ignored otherwise.
REQ-006 SHALL have port cfg_len  input  LEN_W: number of samples to issue per run; sampled on the accepted start.
REQ-007 SHALL have port req_valid  input  N_REQ: per-requester sample valid.
REQ-008 SHALL have port req_data  input  32*N_REQ: per-requester unsigned INT32 Sobol value; requester i occupies bits [32i+31:32i].
REQ-009 SHALL have port req_ready  output  N_REQ: one-hot grant; requester i's sample is consumed when req_valid[i] and req_ready[i] are both high.
REQ-010 SHALL have port out_valid  output  1: output sample valid.
REQ-011 SHALL have port out_fp16  output  16: converted value {exp[4:0], mant[10:0]}.
REQ-012 SHALL have port out_id  output  2: index of the requester that sourced out_fp16.
REQ-013 SHALL have port out_ready  input  1: downstream accept.
REQ-014 SHALL have port busy  output  1: high in RUN and DRAIN.
REQ-015 SHALL have port done  output  1: one-cycle pulse on completion of a run.

Function
REQ-016 SHALL use FSM states IDLE, RUN, DRAIN, DONE; transitions: IDLE->RUN on start, with issued counter cleared and cfg_len latched; RUN->DRAIN when the issued count equals the latched length; DRAIN->DONE when out_valid is low or out_ready is high; DONE->IDLE unconditionally.
REQ-017 SHALL go RUN->DRAIN immediately, with no grants, when start is accepted with cfg_len = 0.
REQ-018 SHALL assert req_ready (combinational) only in RUN, with issued < length, with the output register free (out_valid low or out_ready high), and for exactly one requester with req_valid high.
REQ-019 SHALL arbitrate round-robin: search starts at pointer ptr, ptr resets to 0, and ptr becomes (granted index + 1) mod N_REQ after each grant; ptr is unchanged when no grant occurs.
REQ-020 SHALL convert the granted value: MSO = index of the highest set bit if ≥ 12, else 11; exp = MSO; mant = bits [MSO:MSO-10] of the value.
REQ-021 SHALL register the conversion with latency 1: a grant at edge k makes out_valid, out_fp16 and out_id valid after edge k.
REQ-022 SHALL sustain a throughput of one sample per cycle while out_ready stays high.
REQ-023 SHALL hold out_valid, out_fp16 and out_id stable while out_valid is high and out_ready is low; out_valid clears on acceptance when there is no new grant.
REQ-024 SHALL increment the issued counter by 1 per grant; the counter saturates at the latched length and never wraps.
REQ-025 SHALL ignore start outside IDLE; a run is not restarted.
REQ-026 SHALL treat a requester dropping req_valid without a grant as legal; the requester is simply skipped.
REQ-027 SHALL pulse done high for exactly the DONE cycle; busy is low in IDLE and DONE.

Reset
REQ-028 SHALL, on rst_n low (asynchronous, including mid-run), force state IDLE, ptr 0, issued 0, out_valid 0, out_fp16 0x0000, out_id 0, done 0, busy 0; req_ready is 0 while reset is held.
REQ-029 SHALL discard any in-flight sample on reset, and SHALL require a new start after reset release.

Verification
REQ-030 SHALL cover conversion: values 0x00000000, 0x00000FFF, 0x00001000, 0x80000000 -> out_fp16 0x5800, 0x5FFF, 0x6400, 0xFC00.
REQ-031 SHALL cover fairness: all 4 req_valid held high, cfg_len 8, out_ready 1 -> out_id sequence 0,1,2,3,0,1,2,3, then done 3 cycles after the last grant.
REQ-032 SHALL cover backpressure: out_ready low for 5 cycles mid-run -> outputs held constant, req_ready 0, no sample lost or duplicated.
REQ-033 SHALL cover zero length: start with cfg_len 0 -> no req_ready, done pulses within 3 cycles.
REQ-034 SHALL cover reset mid-run: rst_n low after 3 of 8 grants -> all outputs at reset values in the same cycle; a new start runs a full 8 samples beginning at id 0.
REQ-035 SHALL cover sparse requests: only req_valid[2] high, cfg_len 3 -> three samples, all with out_id 2.

Source files
------------

// File: rtl/sobol_fp16_scheduler.sv
// Round-robin scheduler that funnels N_REQ Sobol INT32 streams through one registered
// INT32-to-FP16 (5-bit exponent, 11-bit truncated mantissa) conversion stage.
module sobol_fp16_scheduler #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned LEN_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [LEN_W-1:0]     cfg_len,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [32*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 out_valid,
  output logic [15:0]          out_fp16,
  output logic [1:0]           out_id,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  state_e            state_q;
  logic [IdxW-1:0]   ptr_q;
  logic [LEN_W-1:0]  issued_q;
  logic [LEN_W-1:0]  len_q;
  logic              out_valid_q;
  logic [15:0]       out_fp16_q;
  logic [1:0]        out_id_q;
  logic              busy_q;
  logic              done_q;

  logic              can_grant;
  logic              grant_any;
  logic [IdxW-1:0]   grant_idx;
  logic [IdxW-1:0]   cand_idx;
  logic [31:0]       grant_data;
  logic [4:0]        mso;
  logic [10:0]       conv_mant;
  logic [15:0]       conv_fp16;
  logic [IdxW-1:0]   ptr_next;

  // A grant needs room in the output register, which frees up on the same edge it is accepted.
  assign can_grant = (state_q == StRun) && (issued_q < len_q) && (!out_valid_q || out_ready);

  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    cand_idx  = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand_idx = IdxW'((32'(ptr_q) + i) % N_REQ);
      if (can_grant && !grant_any && req_valid[cand_idx]) begin
        grant_any = 1'b1;
        grant_idx = cand_idx;
      end
    end
    req_ready = '0;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
    end
  end

  always_comb begin
    if (grant_idx == IdxW'(N_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = grant_idx + 1'b1;
    end
  end

  // Values below 2^12 share exponent 11 so the mantissa keeps its fixed 11-bit window.
  always_comb begin
    grant_data = req_data[32*grant_idx +: 32];
    mso        = 5'd11;
    for (int b = 12; b < 32; b++) begin
      if (grant_data[b]) begin
        mso = 5'(b);
      end
    end
    conv_mant = 11'(grant_data >> (mso - 5'd10));
    conv_fp16 = {mso, conv_mant};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      issued_q    <= '0;
      len_q       <= '0;
      out_valid_q <= 1'b0;
      out_fp16_q  <= 16'h0000;
      out_id_q    <= 2'd0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            state_q  <= StRun;
            len_q    <= cfg_len;
            issued_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        StRun: begin
          if (grant_any && (issued_q != len_q)) begin
            issued_q <= issued_q + 1'b1;
          end
          if (issued_q == len_q) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (!out_valid_q || out_ready) begin
            state_q <= StDone;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase

      if (grant_any) begin
        ptr_q       <= ptr_next;
        out_valid_q <= 1'b1;
        out_fp16_q  <= conv_fp16;
        out_id_q    <= 2'(grant_idx);
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_fp16  = out_fp16_q;
  assign out_id    = out_id_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_sobol_fp16_scheduler.sv
// Scoreboard bench: directed runs push expected {id, fp16} into a queue that a
// negedge monitor drains on every output handshake.
module tb_sobol_fp16_scheduler;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [15:0]  cfg_len = '0;
  logic [3:0]   req_valid = '0;
  logic [127:0] req_data = '0;
  logic [3:0]   req_ready;
  logic         out_valid;
  logic [15:0]  out_fp16;
  logic [1:0]   out_id;
  logic         out_ready = 1'b0;
  logic         busy;
  logic         done;

  int n_cmp = 0;
  int n_err = 0;
  logic [17:0] exp_q[$];
  logic [15:0] fp_tab[4];

  sobol_fp16_scheduler #(.N_REQ(4), .LEN_W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .cfg_len   (cfg_len),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_fp16  (out_fp16),
    .out_id    (out_id),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted output must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", {14'd0, out_id, out_fp16}, 32'hFFFF_FFFF);
      end else begin
        check("out_sample", {14'd0, out_id, out_fp16}, {14'd0, exp_q.pop_front()});
      end
    end
  end

  task automatic push_seq(input int n);
    for (int i = 0; i < n; i++) begin
      exp_q.push_back({2'(i % 4), fp_tab[i % 4]});
    end
  endtask

  task automatic run_start(input logic [15:0] len);
    @(posedge clk);
    #1 cfg_len = len;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    check(name, 32'(seen), 32'd1);
    @(negedge clk);
    check({name, "_pulse_width"}, 32'(done), 32'd0);
  endtask

  task automatic count_grants(input int n, input int budget);
    int g = 0;
    for (int i = 0; i < budget && g < n; i++) begin
      @(negedge clk);
      if (|(req_valid & req_ready)) g++;
    end
    check("grant_budget", 32'(g), 32'(n));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    int since;
    bit seen;
    bit rr_seen;

    fp_tab[0] = 16'h5800;
    fp_tab[1] = 16'h5FFF;
    fp_tab[2] = 16'h6400;
    fp_tab[3] = 16'hFC00;
    req_data = {32'h8000_0000, 32'h0000_1000, 32'h0000_0FFF, 32'h0000_0000};

    // Reset state
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_fp16", 32'(out_fp16), 32'd0);
    check("rst_out_id", 32'(out_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    req_valid = 4'hF;
    #1 check("rst_req_ready", 32'(req_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Fairness and conversion: ids 0..3 twice, done soon after last grant
    out_ready = 1'b1;
    push_seq(8);
    run_start(16'd8);
    g = 0;
    since = 0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (i == 0) check("fair_busy", 32'(busy), 32'd1);
      if (done) begin
        seen = 1'b1;
      end else if (|(req_valid & req_ready)) begin
        g++;
        since = 0;
      end else begin
        since++;
      end
    end
    check("fair_grants", 32'(g), 32'd8);
    check("fair_done_seen", 32'(seen), 32'd1);
    check("fair_done_latency", 32'(since < 3), 32'd1);
    @(negedge clk);
    check("fair_done_pulse", 32'(done), 32'd0);
    check("fair_busy_idle", 32'(busy), 32'd0);
    check("fair_sb_empty", 32'(exp_q.size()), 32'd0);

    // Backpressure mid-run, with an ignored start
    push_seq(8);
    run_start(16'd8);
    count_grants(3, 20);
    @(posedge clk);
    #1 out_ready = 1'b0;
    cfg_len = 16'd2;
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (i == 0) start = 1'b0;
      check("bp_valid_held", 32'(out_valid), 32'd1);
      check("bp_data_held", {14'd0, out_id, out_fp16}, {14'd0, exp_q[0]});
      check("bp_no_grant", 32'(req_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    wait_done("bp_done", 30);
    check("bp_sb_empty", 32'(exp_q.size()), 32'd0);

    // Zero length
    run_start(16'd0);
    seen = 1'b0;
    rr_seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
      if (|req_ready) rr_seen = 1'b1;
    end
    check("zero_done", 32'(seen), 32'd1);
    check("zero_no_ready", 32'(rr_seen), 32'd0);
    check("zero_no_out", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);

    // Reset mid-run after 3 of 8 grants
    push_seq(3);
    run_start(16'd8);
    count_grants(3, 20);
    @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_fp16", 32'(out_fp16), 32'd0);
    check("mid_rst_out_id", 32'(out_id), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_req_ready", 32'(req_ready), 32'd0);
    check("mid_rst_sb_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_no_autostart", 32'(busy), 32'd0);
    push_seq(8);
    run_start(16'd8);
    wait_done("post_rst_done", 40);
    check("post_rst_sb_empty", 32'(exp_q.size()), 32'd0);

    // Sparse: only requester 2, value 0x00012345 -> 0x848D
    req_valid = 4'b0100;
    req_data[95:64] = 32'h0001_2345;
    for (int i = 0; i < 3; i++) exp_q.push_back({2'd2, 16'h848D});
    run_start(16'd3);
    wait_done("sparse_done", 30);
    check("sparse_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
